fifo_packer: RTL

FIFO_PACKER -- requirements
Module: fifo_packer

---
 rtl/fifo_packer_pkg.sv | 10 +
 rtl/fifo_packer.sv | 104 ++++++++++
 2 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types and default geometry for the FIFO word packer.
// Optional parity output is enabled with FIFO_PACKER_PARITY_EN.
package fifo_packer_pkg;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/fifo_packer.sv
// Packs `words` consecutive FIFO words into one wide beat with a valid/ready handshake.
// Define FIFO_PACKER_PARITY_EN to add a registered XOR-reduction output out_parity.
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int words = DEF_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [width-1:0]           fifo_dout,
  input  logic                       fifo_pndng,
  output logic                       fifo_pop,
  input  logic                       flush,
  output logic [width*words-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(words+1)-1:0] out_count,
  output logic [31:0]                beat_cnt
`ifdef FIFO_PACKER_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int IW = $clog2(words);
  localparam int CW = $clog2(words + 1);
  localparam logic [IW-1:0] LAST = IW'(words - 1);

  state_t                   state, state_n;
  logic [IW-1:0]            idx, idx_n;
  logic [width*words-1:0]   data_n;
  logic [CW-1:0]            count_n;
  logic                     valid_n;
  logic [31:0]              cnt_n;

  // Pop only while collecting; HOLD (including the handshake cycle) leaves a bubble.
  assign fifo_pop = fifo_pndng && (state == COLLECT) && !rst;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = out_data;
    count_n = out_count;
    valid_n = out_valid;
    cnt_n   = beat_cnt;
    case (state)
      COLLECT: begin
        if (fifo_pop) begin
          data_n[int'(idx)*width +: width] = fifo_dout;
          if (idx == LAST || flush) begin
            state_n = HOLD;
            valid_n = 1'b1;
            count_n = CW'(idx) + CW'(1);
          end else begin
            idx_n = idx + IW'(1);
          end
        end else if (flush && idx != '0) begin
          state_n = HOLD;
          valid_n = 1'b1;
          count_n = CW'(idx);
        end
      end
      HOLD: begin
        // Clearing data here is what keeps unfilled slots of the next partial beat at zero.
        if (out_ready) begin
          state_n = COLLECT;
          idx_n   = '0;
          data_n  = '0;
          count_n = '0;
          valid_n = 1'b0;
          cnt_n   = beat_cnt + 32'd1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_data  <= data_n;
      out_count <= count_n;
      out_valid <= valid_n;
      beat_cnt  <= cnt_n;
    end
  end

`ifdef FIFO_PACKER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_parity <= 1'b0;
    else     out_parity <= ^data_n;
  end
`endif

endmodule
